// File: rtl/dbg_ocimem_pkg.sv
// dbg_ocimem_pkg: state encoding and jdo field positions shared by the OCI memory controller
package dbg_ocimem_pkg;
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
    localparam int JDO_RDREQ_BIT = 35;
    localparam int JDO_INCR_BIT = 34;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_WDATA_LSB = 3;
endpackage

// File: rtl/dbg_ocimem_ctrl_if.sv
// dbg_ocimem_ctrl_if: Avalon-MM link between the OCI memory controller (master) and the debug RAM/ROM (slave)
// address/read/write/writedata flow master->slave; waitrequest/readdata/readdatavalid flow back
interface dbg_ocimem_ctrl_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] address;
    logic read;
    logic write;
    logic [31:0] writedata;
    logic waitrequest;
    logic [31:0] readdata;
    logic readdatavalid;
    modport master(output address, read, write, writedata, input waitrequest, readdata, readdatavalid);
    modport slave(input address, read, write, writedata, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/dbg_ocimem_timeout.sv
// dbg_ocimem_timeout: loadable down-counter; expire pulses on the TIMEOUT_CYC-th enabled cycle after load
// load restarts the count, en marks a busy cycle, expire is high while busy with the count exhausted
module dbg_ocimem_timeout #(parameter int TIMEOUT_CYC = 255) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYC);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= W'(TIMEOUT_CYC - 1);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign expire = en && cnt == '0;
endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// dbg_ocimem_ctrl: turns decoded JTAG action strobes into Avalon-MM accesses to the debug memory
// inputs: jdo + three action strobes; mem: Avalon master port; outputs: MonDReg, monitor_ready, monitor_error
module dbg_ocimem_ctrl
    import dbg_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic [37:0] jdo,
    input  logic take_action_ocimem_a,
    input  logic take_action_ocimem_b,
    input  logic take_no_action_ocimem_a,
    dbg_ocimem_ctrl_if.master mem,
    output logic [31:0] MonDReg,
    output logic monitor_ready,
    output logic monitor_error
);
    state_t state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata;
    logic incr, idle, any_stb, rd_cmd, wr_cmd, rd_done, wr_done, done, expire, abort;
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[JDO_WDATA_LSB-1:0]};
    assign idle = state == IDLE;
    assign any_stb = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
    assign rd_cmd = idle && (take_action_ocimem_a ? jdo[JDO_RDREQ_BIT] : !take_action_ocimem_b && take_no_action_ocimem_a);
    assign wr_cmd = idle && !take_action_ocimem_a && take_action_ocimem_b;
    // a zero-latency slave may return data in the same cycle it accepts the read
    assign rd_done = mem.readdatavalid && (state == RD_WAIT || (state == RD_REQ && !mem.waitrequest));
    assign wr_done = state == WR_REQ && !mem.waitrequest;
    assign done = rd_done || wr_done;
    assign abort = expire && !done;
    dbg_ocimem_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk(clk),
        .reset(reset),
        .load(rd_cmd || wr_cmd),
        .en(!idle),
        .expire(expire)
    );
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb
        state_n = (done || abort) ? IDLE :
                  idle ? (rd_cmd ? RD_REQ : wr_cmd ? WR_REQ : IDLE) :
                  (state == RD_REQ && !mem.waitrequest) ? RD_WAIT : state;
    always_comb begin
        mem.read = state == RD_REQ;
        mem.write = state == WR_REQ;
    end
    assign mem.address = addr;
    assign mem.writedata = wdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            incr <= 1'b0;
            wdata <= '0;
            MonDReg <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (idle && take_action_ocimem_a) begin
                addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                incr <= jdo[JDO_INCR_BIT];
            end else if (done && incr) addr <= addr + 1'b1;
            if (wr_cmd) wdata <= jdo[JDO_WDATA_LSB +: 32];
            if (rd_cmd || wr_cmd) monitor_ready <= 1'b0;
            else if (done || abort) monitor_ready <= 1'b1;
            if (rd_done) MonDReg <= mem.readdata;
            else if (wr_done) MonDReg <= wdata;
            // strobes arriving while busy are dropped but flagged
            if (idle && take_action_ocimem_a) monitor_error <= 1'b0;
            else if ((!idle && any_stb) || abort) monitor_error <= 1'b1;
        end
    end
endmodule

// File: doc/dbg_ocimem_ctrl.md
Name: dbg_ocimem_ctrl

Overview:
- Sysclk-domain consumer of the debug slave's decoded JTAG actions (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Turns those one-cycle action strobes into Avalon-MM reads and writes against the on-chip debug memory.
- Returns MonDReg, monitor_ready and monitor_error, which the debug slave shifts back to the host.
- Sits between the debug slave wrapper and the debug RAM/ROM.

Parameters:
- ADDR_W, 8, word-address width of the debug memory.
- TIMEOUT_CYC, 255, maximum cycles to wait on waitrequest/readdatavalid before aborting (must be ≥ 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  JTAG data captured by the debug slave.
- take_action_ocimem_a  in  1  one-cycle strobe: load address/mode.
- take_action_ocimem_b  in  1  one-cycle strobe: write word.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read-next.
- mem_address  out  ADDR_W  word address.
- mem_read  out  1  Avalon read.
- mem_write  out  1  Avalon write.
- mem_writedata  out  32  write data.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  32  read data.
- mem_readdatavalid  in  1  read data qualifier.
- MonDReg  out  32  last read (or written) data word.
- monitor_ready  out  1  high when the last command has completed.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE; addr=0, incr=0, timeout counter=0.
- Field map for take_action_ocimem_a:
  - addr ← jdo[17+ADDR_W-1:17].
  - incr ← jdo[34].
  - jdo[35]=1 additionally issues a read at the new address.
  - Clears monitor_error.
- Field map for take_action_ocimem_b: write jdo[34:3] to addr.
- take_no_action_ocimem_a: read at addr.
- Strobe priority on the same cycle: ocimem_a > ocimem_b > no_action_ocimem_a. Lower-priority strobes in that cycle are discarded silently.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE:
  - Read command → RD_REQ, mem_read=1 on the next cycle.
  - Write command → WR_REQ, mem_write=1, mem_writedata latched on the next cycle.
  - Accepting any memory command drives monitor_ready to 0 on the next cycle.
  - ocimem_a without a read only updates the registers; monitor_ready is unchanged.
- RD_REQ:
  - Hold mem_read, mem_address stable while mem_waitrequest=1.
  - On waitrequest=0, drop mem_read → RD_WAIT.
  - If readdatavalid arrives on the same cycle as waitrequest=0, complete immediately (zero-latency slave).
- RD_WAIT: on readdatavalid, MonDReg ← mem_readdata, monitor_ready=1 next cycle → IDLE.
- WR_REQ: hold mem_write, mem_address and mem_writedata while waitrequest=1. On waitrequest=0:
  - MonDReg ← written data.
  - monitor_ready=1.
  - → IDLE.
- Post-increment: on each successful completion with incr=1, addr ← addr+1 mod 2^ADDR_W. Wrap from all-ones to 0 is silent.
- Timeout:
  - Counter clears on entry to any non-IDLE state and increments each non-IDLE cycle.
  - At TIMEOUT_CYC: deassert read/write, monitor_error=1, monitor_ready=1, MonDReg unchanged, no increment, → IDLE.
- Busy collision: any strobe while not IDLE is dropped and sets monitor_error=1. The in-flight transfer continues unaffected.
- Latency: zero-wait write completes (monitor_ready=1) 2 cycles after the strobe. Zero-wait read with 1-cycle readdatavalid completes in 3 cycles.
- Reset mid-transfer: mem_read/mem_write drop in the same clock edge as reset. Any late readdatavalid while in IDLE is ignored.

Decomposition:
- Shared package dbg_ocimem_pkg holds:
  - State enum.
  - jdo field position constants: JDO_RDREQ_BIT=35, JDO_INCR_BIT=34, JDO_ADDR_LSB=17, JDO_WDATA_LSB=3.
- One natural sub-module: dbg_ocimem_timeout, a loadable down-counter producing an expire pulse.

Test Plan:
- ocimem_a with jdo[35]=1, addr=0x10, incr=0; slave returns 0xDEADBEEF one cycle after the read with no wait → MonDReg=0xDEADBEEF, ready=1 three cycles after the strobe, addr stays 0x10.
- ocimem_a addr=0xFF, incr=1, then three ocimem_b writes of 0x1, 0x2, 0x3 → mem_address sequence 0xFF, 0x00, 0x01 (wrap), addr ends at 0x02.
- Write with waitrequest held for 5 cycles → mem_write and mem_writedata stable for 6 cycles, ready=1 after release, no error.
- Read with readdatavalid never asserted, TIMEOUT_CYC=8 → error=1, ready=1 at cycle 8, MonDReg unchanged, addr not incremented. A following ocimem_a clears error.
- ocimem_b issued during RD_WAIT → no second transfer, error=1, in-flight read still completes with correct MonDReg.
- Reset asserted during WR_REQ with waitrequest=1 → mem_write=0 next cycle, all outputs 0, next ocimem_a behaves normally.
